vscale_pc_gen: RTL and testbench

- Parametrised next-PC generator and fetch-PC register for the vscale front end.
- Selects the next fetch address from sequential, JAL, JALR, branch, replay, handler and EPC sources, and owns the PC_IF register.
- Redirects that arrive while imem is stalled are captured and held until the fetch is accepted; they are no longer dropped.
- Misaligned-target detection is registered, which removes the combinational loop through imem.

---
 rtl/vscale_pc_gen_pkg.sv | 30 +++
 rtl/vscale_pc_gen_if.sv | 30 +++
 rtl/vscale_pc_gen_target.sv | 47 ++++
 rtl/vscale_pc_gen.sv | 145 ++++++++++++++
 tb/tb_vscale_pc_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/vscale_pc_gen_pkg.sv
// Shared constants for the vscale next-PC generator: PC source encodings,
// widths and FSM state encodings.
package vscale_pc_gen_pkg;

    localparam int PKG_XPR_LEN      = 32;
    localparam int INST_WIDTH       = 32;
    localparam int PC_SRC_SEL_WIDTH = 3;

    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_PLUS4         = 3'd0;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_BRANCH_TARGET = 3'd1;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_JAL_TARGET    = 3'd2;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_JALR_TARGET   = 3'd3;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_REPLAY        = 3'd4;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_HANDLER       = 3'd5;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_EPC           = 3'd6;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } pc_state_e;

    // A redirect is any source that leaves the sequential/replay stream.
    function automatic logic is_redirect(input logic [PC_SRC_SEL_WIDTH-1:0] sel);
        return (sel == PC_JAL_TARGET) || (sel == PC_JALR_TARGET) ||
               (sel == PC_BRANCH_TARGET) || (sel == PC_HANDLER) ||
               (sel == PC_EPC);
    endfunction

endpackage

// File: rtl/vscale_pc_gen_if.sv
// Front-end bus between the core control/datapath (master) and the
// next-PC generator (slave).
interface vscale_pc_gen_if
    import vscale_pc_gen_pkg::*;
#(
    parameter int XPR_LEN = PKG_XPR_LEN
);
    logic [PC_SRC_SEL_WIDTH-1:0] PC_src_sel;
    logic [INST_WIDTH-1:0]       inst_DX;
    logic [XPR_LEN-1:0]          PC_DX;
    logic [XPR_LEN-1:0]          rs1_data;
    logic [XPR_LEN-1:0]          handler_PC;
    logic [XPR_LEN-1:0]          epc;
    logic                        imem_wait;
    logic [XPR_LEN-1:0]          PC_PIF;
    logic [XPR_LEN-1:0]          PC_IF;
    logic                        redirect_pending;
    logic                        misaligned_fetch;
    logic [XPR_LEN-1:0]          misaligned_addr;

    modport master (
        output PC_src_sel, inst_DX, PC_DX, rs1_data, handler_PC, epc, imem_wait,
        input  PC_PIF, PC_IF, redirect_pending, misaligned_fetch, misaligned_addr
    );

    modport slave (
        input  PC_src_sel, inst_DX, PC_DX, rs1_data, handler_PC, epc, imem_wait,
        output PC_PIF, PC_IF, redirect_pending, misaligned_fetch, misaligned_addr
    );
endinterface

// File: rtl/vscale_pc_gen_target.sv
// Combinational target calculation: immediate extraction plus the adders
// for JAL/JALR/branch, and the mux over all PC sources. No alignment here.
module vscale_pc_target
    import vscale_pc_gen_pkg::*;
#(
    parameter int XPR_LEN     = PKG_XPR_LEN,
    parameter int FETCH_BYTES = 4
) (
    input  logic [PC_SRC_SEL_WIDTH-1:0] i_sel,
    input  logic [INST_WIDTH-1:0]       i_inst,
    input  logic [XPR_LEN-1:0]          i_pc_dx,
    input  logic [XPR_LEN-1:0]          i_rs1,
    input  logic [XPR_LEN-1:0]          i_handler_pc,
    input  logic [XPR_LEN-1:0]          i_epc,
    input  logic [XPR_LEN-1:0]          i_pc_if,
    output logic [XPR_LEN-1:0]          o_target,
    output logic                        o_redirect
);
    logic [XPR_LEN-1:0] w_j_imm;
    logic [XPR_LEN-1:0] w_i_imm;
    logic [XPR_LEN-1:0] w_b_imm;
    logic [XPR_LEN-1:0] w_jalr_sum;
    logic               w_unused_opcode;

    assign w_j_imm = {{(XPR_LEN-20){i_inst[31]}}, i_inst[19:12], i_inst[20],
                      i_inst[30:21], 1'b0};
    assign w_i_imm = {{(XPR_LEN-12){i_inst[31]}}, i_inst[31:20]};
    assign w_b_imm = {{(XPR_LEN-12){i_inst[31]}}, i_inst[7], i_inst[30:25],
                      i_inst[11:8], 1'b0};
    assign w_jalr_sum      = i_rs1 + w_i_imm;
    assign w_unused_opcode = ^i_inst[6:0];
    assign o_redirect      = is_redirect(i_sel);

    // Source mux; every sum wraps silently at XPR_LEN bits.
    always_comb begin
        o_target = i_pc_if + XPR_LEN'(FETCH_BYTES);
        case (i_sel)
            PC_JAL_TARGET:    o_target = i_pc_dx + w_j_imm;
            PC_JALR_TARGET:   o_target = {w_jalr_sum[XPR_LEN-1:1], 1'b0};
            PC_BRANCH_TARGET: o_target = i_pc_dx + w_b_imm;
            PC_HANDLER:       o_target = i_handler_pc;
            PC_EPC:           o_target = i_epc;
            PC_REPLAY:        o_target = i_pc_if;
            default:          o_target = i_pc_if + XPR_LEN'(FETCH_BYTES);
        endcase
    end
endmodule

// File: rtl/vscale_pc_gen.sv
// Next-PC generator and PC_IF register. Redirects seen during an imem stall
// are held in pend_pc until the fetch is accepted (youngest wins).
// Optional build macro VSCALE_PC_GEN_MISALIGN_EN: misaligned targets are
// suppressed and reported one cycle later; otherwise low bits are cleared.
//
// state | meaning
// BOOT  | presenting RESET_PC, waiting for imem to accept it
// RUN   | normal fetch, target issued whenever imem accepts
// PEND  | a redirect is held in pend_pc, issued on first accepted cycle
module vscale_pc_gen
    import vscale_pc_gen_pkg::*;
#(
    parameter int                 XPR_LEN     = PKG_XPR_LEN,
    parameter logic [XPR_LEN-1:0] RESET_PC    = 'h200,
    parameter int                 FETCH_BYTES = 4,
    parameter int                 IALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    vscale_pc_gen_if.slave   bus
);
    localparam logic [XPR_LEN-1:0] ALIGN_MASK = ~((XPR_LEN'(1) << IALIGN_BITS) - XPR_LEN'(1));

    pc_state_e          r_state;
    pc_state_e          w_state_nxt;
    logic [XPR_LEN-1:0] r_pc_if;
    logic [XPR_LEN-1:0] r_pend_pc;
    logic [XPR_LEN-1:0] w_target_raw;
    logic [XPR_LEN-1:0] w_target;
    logic [XPR_LEN-1:0] w_issue;
    logic [XPR_LEN-1:0] w_pc_pif;
    logic               w_redirect;
    logic               w_mis;
    logic               w_pc_if_load;
    logic               w_pend_load;

    vscale_pc_target #(
        .XPR_LEN     (XPR_LEN),
        .FETCH_BYTES (FETCH_BYTES)
    ) u_target (
        .i_sel        (bus.PC_src_sel),
        .i_inst       (bus.inst_DX),
        .i_pc_dx      (bus.PC_DX),
        .i_rs1        (bus.rs1_data),
        .i_handler_pc (bus.handler_PC),
        .i_epc        (bus.epc),
        .i_pc_if      (r_pc_if),
        .o_target     (w_target_raw),
        .o_redirect   (w_redirect)
    );

    // In PEND a fresh redirect replaces the held one; otherwise the held one is issued.
    assign w_issue = ((r_state == ST_PEND) && !w_redirect) ? r_pend_pc : w_target;

`ifdef VSCALE_PC_GEN_MISALIGN_EN
    logic               r_mis_fetch;
    logic [XPR_LEN-1:0] r_mis_addr;

    assign w_target = w_target_raw;
    assign w_mis    = (r_state != ST_BOOT) && !bus.imem_wait &&
                      ((w_issue & ~ALIGN_MASK) != '0);

    // Registered misalignment report; the flag never feeds back into PC_PIF.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mis_fetch <= 1'b0;
            r_mis_addr  <= '0;
        end else begin
            r_mis_fetch <= w_mis;
            if (w_mis) begin
                r_mis_addr <= w_issue;
            end
        end
    end

    assign bus.misaligned_fetch = r_mis_fetch;
    assign bus.misaligned_addr  = r_mis_addr;
`else
    assign w_target             = w_target_raw & ALIGN_MASK;
    assign w_mis                = 1'b0;
    assign bus.misaligned_fetch = 1'b0;
    assign bus.misaligned_addr  = '0;
`endif

    // Next-state, fetch address and register load enables.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_pif     = r_pc_if;
        w_pc_if_load = 1'b0;
        w_pend_load  = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_pc_pif = RESET_PC;
                if (!bus.imem_wait) begin
                    w_pc_if_load = 1'b1;
                    w_state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.imem_wait) begin
                    if (!w_mis) begin
                        w_pc_pif     = w_issue;
                        w_pc_if_load = 1'b1;
                    end
                end else if (w_redirect) begin
                    w_pend_load = 1'b1;
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!bus.imem_wait) begin
                    if (!w_mis) begin
                        w_pc_pif     = w_issue;
                        w_pc_if_load = 1'b1;
                    end
                    w_state_nxt = ST_RUN;
                end else if (w_redirect) begin
                    w_pend_load = 1'b1;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // State, PC_IF and held-redirect registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_BOOT;
            r_pc_if   <= RESET_PC;
            r_pend_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_if_load) begin
                r_pc_if <= w_pc_pif;
            end
            if (w_pend_load) begin
                r_pend_pc <= w_target;
            end
        end
    end

    assign bus.PC_PIF           = w_pc_pif;
    assign bus.PC_IF            = r_pc_if;
    assign bus.redirect_pending = (r_state == ST_PEND);
endmodule

// File: tb/tb_vscale_pc_gen.sv
// Bench for vscale_pc_gen: directed scenarios followed by random traffic,
// all checked against a behavioural model of the fetch-PC rules.
module tb_vscale_pc_gen;
    import vscale_pc_gen_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vscale_pc_gen_if bus ();

    vscale_pc_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_boot;
    bit          m_pend;
    bit          m_mis;
    logic [31:0] m_pc_if;
    logic [31:0] m_pend_pc;
    logic [31:0] m_mis_addr;
    logic [31:0] obs_pif;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Place the immediate into the instruction fields used by each format.
    function automatic logic [31:0] enc_inst(input logic [2:0] sel, input logic [31:0] imm,
                                             input logic [31:0] noise);
        logic [31:0] in;
        in = noise;
        case (sel)
            PC_JAL_TARGET: begin
                in[31]    = imm[20];
                in[19:12] = imm[19:12];
                in[20]    = imm[11];
                in[30:21] = imm[10:1];
            end
            PC_JALR_TARGET: in[31:20] = imm[11:0];
            PC_BRANCH_TARGET: begin
                in[31]    = imm[12];
                in[7]     = imm[11];
                in[30:25] = imm[10:5];
                in[11:8]  = imm[4:1];
            end
            default: ;
        endcase
        return in;
    endfunction

    function automatic logic [31:0] model_target(input logic [2:0] sel, input logic [31:0] imm,
                                                 input logic [31:0] pc_dx, input logic [31:0] rs1,
                                                 input logic [31:0] hpc, input logic [31:0] ep);
        longint      off;
        logic [31:0] t;
        case (sel)
            PC_JAL_TARGET: begin
                off = $signed({imm[20:1], 1'b0});
                t   = pc_dx + 32'(off);
            end
            PC_JALR_TARGET: begin
                off = $signed(imm[11:0]);
                t   = (rs1 + 32'(off)) & ~32'd1;
            end
            PC_BRANCH_TARGET: begin
                off = $signed({imm[12:1], 1'b0});
                t   = pc_dx + 32'(off);
            end
            PC_HANDLER: t = hpc;
            PC_EPC:     t = ep;
            PC_REPLAY:  t = m_pc_if;
            default:    t = m_pc_if + 32'd4;
        endcase
`ifndef VSCALE_PC_GEN_MISALIGN_EN
        t = t & ~32'd3;
`endif
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.imem_wait = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_pc_if", bus.PC_IF, 32'h200);
        chk("rst_pc_pif", bus.PC_PIF, 32'h200);
        chk("rst_pending", 32'(bus.redirect_pending), 32'd0);
        chk("rst_mis_fetch", 32'(bus.misaligned_fetch), 32'd0);
        chk("rst_mis_addr", bus.misaligned_addr, 32'd0);
        m_boot = 1'b1;
        m_pend = 1'b0;
        m_mis = 1'b0;
        m_pc_if = 32'h200;
        m_pend_pc = 32'd0;
        m_mis_addr = 32'd0;
        #2;
        reset_n = 1'b1;
    endtask

    // One clock: drive at negedge, check PC_PIF, then check registers after posedge.
    task automatic cycle(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] pc_dx,
                         input logic [31:0] rs1, input logic [31:0] hpc, input logic [31:0] ep,
                         input bit wt);
        logic [31:0] tgt;
        logic [31:0] issue;
        logic [31:0] exp_pif;
        bit          redir;
        bit          mis;
        @(negedge clk);
        bus.PC_src_sel = sel;
        bus.inst_DX    = enc_inst(sel, imm, $urandom);
        bus.PC_DX      = pc_dx;
        bus.rs1_data   = rs1;
        bus.handler_PC = hpc;
        bus.epc        = ep;
        bus.imem_wait  = wt;
        #1;
        tgt   = model_target(sel, imm, pc_dx, rs1, hpc, ep);
        redir = sel inside {PC_JAL_TARGET, PC_JALR_TARGET, PC_BRANCH_TARGET, PC_HANDLER, PC_EPC};
        issue = (m_pend && !redir) ? m_pend_pc : tgt;
        mis   = 1'b0;
`ifdef VSCALE_PC_GEN_MISALIGN_EN
        mis = !m_boot && !wt && (issue[1:0] != 2'b00);
`endif
        if (m_boot)          exp_pif = 32'h200;
        else if (wt || mis)  exp_pif = m_pc_if;
        else                 exp_pif = issue;
        obs_pif = bus.PC_PIF;
        chk("pc_pif", bus.PC_PIF, exp_pif);
        if (!wt) begin
            if (!mis) m_pc_if = exp_pif;
            m_boot = 1'b0;
            m_pend = 1'b0;
        end else if (!m_boot && redir) begin
            m_pend    = 1'b1;
            m_pend_pc = tgt;
        end
        m_mis = mis;
        if (mis) m_mis_addr = issue;
        @(posedge clk);
        #1;
        chk("pc_if", bus.PC_IF, m_pc_if);
        chk("pending", 32'(bus.redirect_pending), 32'(m_pend));
        chk("mis_fetch", 32'(bus.misaligned_fetch), 32'(m_mis));
        chk("mis_addr", bus.misaligned_addr, m_mis_addr);
    endtask

    initial begin
        bus.PC_src_sel = PC_PLUS4;
        bus.inst_DX    = 32'd0;
        bus.PC_DX      = 32'd0;
        bus.rs1_data   = 32'd0;
        bus.handler_PC = 32'd0;
        bus.epc        = 32'd0;
        bus.imem_wait  = 1'b1;

        do_reset();

        cycle(PC_JAL_TARGET, $urandom, $urandom, 0, 0, 0, 1'b0);
        chk("boot_pif", obs_pif, 32'h200);
        chk("boot_pc_if", bus.PC_IF, 32'h200);
        cycle(PC_PLUS4, 0, 0, 0, 0, 0, 1'b0);
        chk("first_seq_pif", obs_pif, 32'h204);

        cycle(PC_JAL_TARGET, 0, 32'h1000, 0, 0, 0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cycle(PC_PLUS4, 0, 0, 0, 0, 0, 1'b0);
            chk("seq_pc_if", bus.PC_IF, 32'h1000 + 32'(4 * i));
        end

        cycle(PC_JAL_TARGET, 32'h40, 32'h2000, 0, 0, 0, 1'b1);
        chk("jal_pending", 32'(bus.redirect_pending), 32'd1);
        for (int i = 0; i < 2; i++) begin
            cycle(PC_PLUS4, 0, 0, 0, 0, 0, 1'b1);
            chk("stall_pif", obs_pif, 32'h100C);
            chk("stall_pending", 32'(bus.redirect_pending), 32'd1);
        end
        cycle(PC_PLUS4, 0, 0, 0, 0, 0, 1'b0);
        chk("jal_release_pif", obs_pif, 32'h2040);
        chk("jal_release_pc_if", bus.PC_IF, 32'h2040);
        chk("jal_release_pending", 32'(bus.redirect_pending), 32'd0);

        cycle(PC_BRANCH_TARGET, 0, 32'h3000, 0, 0, 0, 1'b1);
        cycle(PC_HANDLER, 0, 0, 0, 32'h100, 0, 1'b1);
        cycle(PC_PLUS4, 0, 0, 0, 0, 0, 1'b0);
        chk("handler_wins_pif", obs_pif, 32'h100);

        cycle(PC_JALR_TARGET, 0, 0, 32'h502, 0, 0, 1'b0);
`ifdef VSCALE_PC_GEN_MISALIGN_EN
        chk("misalign_pif", obs_pif, 32'h100);
        chk("misalign_pc_if", bus.PC_IF, 32'h100);
        chk("misalign_flag", 32'(bus.misaligned_fetch), 32'd1);
        chk("misalign_addr", bus.misaligned_addr, 32'h502);
        cycle(PC_PLUS4, 0, 0, 0, 0, 0, 1'b0);
        chk("misalign_flag_drop", 32'(bus.misaligned_fetch), 32'd0);
        chk("misalign_addr_hold", bus.misaligned_addr, 32'h502);
`else
        chk("jalr_aligned_pif", obs_pif, 32'h500);
`endif

        cycle(PC_JAL_TARGET, 0, 32'hFFFF_FFFC, 0, 0, 0, 1'b0);
        cycle(PC_PLUS4, 0, 0, 0, 0, 0, 1'b0);
        chk("wrap_pif", obs_pif, 32'h0000_0000);

        cycle(PC_JAL_TARGET, 32'h40, 32'h2000, 0, 0, 0, 1'b1);
        chk("pre_reset_pending", 32'(bus.redirect_pending), 32'd1);
        do_reset();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end
            cycle(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 9) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
